// File: rtl/uart_cal_ctrl.sv
// uart_cal_ctrl -- command sequencer of the UART calculator.
// Parses "<A><op><B>=" from the rx byte stream, evaluates it and issues one
// 32-bit result word to the tx side; any error issues 32'hFFFF_FFFF.
// Optional feature macro: UART_CAL_TIMEOUT_EN (inter-byte timeout of TO_CYC cycles).
module uart_cal_ctrl #(
  parameter int unsigned OP_W    = 16,
  parameter int unsigned DIV_CYC = OP_W,
  parameter int unsigned TO_CYC  = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_busy,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, OPA, OPB_START, OPB, CALC, DIV, SEND, ERR} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  localparam int unsigned CNT_W = $clog2(DIV_CYC) + 1;

  state_t           state, state_d;
  op_t              op, op_dec;
  logic [OP_W-1:0]  a, b;
  logic [OP_W-1:0]  rem;
  logic [31:0]      res;
  logic [CNT_W-1:0] div_cnt;

  logic             is_digit, is_op, is_eq, is_space, is_clear;
  logic [3:0]       dig;
  logic [OP_W+3:0]  acc;
  logic             acc_ovf;
  logic [OP_W:0]    shifted, trial;
  logic [OP_W-1:0]  rem_d, quo_d;
  logic             in_expr, to_hit;

  // Classify the incoming byte and form the decimal-accumulate candidate
  always_comb begin
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    dig      = rx_data[3:0];
    is_eq    = (rx_data == 8'h3D);
    is_space = (rx_data == 8'h20);
    is_clear = (rx_data == 8'h43) || (rx_data == 8'h0D);
    op_dec   = OP_NONE;
    case (rx_data)
      8'h2B:   op_dec = OP_ADD;
      8'h2D:   op_dec = OP_SUB;
      8'h2A:   op_dec = OP_MUL;
      8'h2F:   op_dec = OP_DIV;
      default: op_dec = OP_NONE;
    endcase
    is_op   = (op_dec != OP_NONE);
    acc     = ({4'd0, ((state == OPA) ? a : b)} * (OP_W+4)'(10)) + (OP_W+4)'(dig);
    acc_ovf = |acc[OP_W+3:OP_W];
  end

  // One restoring-division step; quotient bits shift into a as dividend bits leave
  always_comb begin
    shifted = {rem, a[OP_W-1]};
    trial   = shifted - {1'b0, b};
    if (trial[OP_W]) begin
      rem_d = shifted[OP_W-1:0];
      quo_d = {a[OP_W-2:0], 1'b0};
    end else begin
      rem_d = trial[OP_W-1:0];
      quo_d = {a[OP_W-2:0], 1'b1};
    end
  end

  assign in_expr = (state == OPA) || (state == OPB_START) || (state == OPB);

`ifdef UART_CAL_TIMEOUT_EN
  logic [31:0] to_cnt;

  // Inter-byte timer: restarts on every byte and whenever no expression is open
  always_ff @(posedge clk) begin
    if (rst || rx_valid || !in_expr) to_cnt <= '0;
    else                             to_cnt <= to_cnt + 32'd1;
  end

  assign to_hit = !rx_valid && (to_cnt == 32'(TO_CYC - 1));
`else
  assign to_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state decode; spaces are ignored and bytes outside the parse states are dropped
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (rx_valid && !is_space && !is_clear) state_d = is_digit ? OPA : ERR;
      OPA:       if (rx_valid && !is_space) begin
                   if (is_clear)      state_d = IDLE;
                   else if (is_digit) state_d = acc_ovf ? ERR : OPA;
                   else if (is_op)    state_d = OPB_START;
                   else               state_d = ERR;
                 end
      OPB_START: if (rx_valid && !is_space) state_d = is_clear ? IDLE : (is_digit ? OPB : ERR);
      OPB:       if (rx_valid && !is_space) begin
                   if (is_clear)      state_d = IDLE;
                   else if (is_digit) state_d = acc_ovf ? ERR : OPB;
                   else if (is_eq)    state_d = CALC;
                   else               state_d = ERR;
                 end
      CALC:      if (op == OP_DIV) state_d = (b == '0) ? ERR : DIV;
                 else              state_d = SEND;
      DIV:       if (div_cnt == CNT_W'(DIV_CYC - 1)) state_d = SEND;
      SEND:      if (!tx_busy) state_d = IDLE;
      ERR:       state_d = SEND;
      default:   state_d = IDLE;
    endcase
    if (in_expr && to_hit) state_d = ERR;
  end

  assign busy = (state == CALC) || (state == DIV) || (state == SEND);
  assign err  = (state == ERR);

  // Operand, operator, divider and tx registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a        <= '0;
      b        <= '0;
      op       <= OP_NONE;
      rem      <= '0;
      res      <= '0;
      div_cnt  <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      case (state)
        IDLE:      if (rx_valid && is_digit) a <= OP_W'(dig);
        OPA:       if (rx_valid) begin
                     if (is_digit) a  <= acc[OP_W-1:0];
                     if (is_op)    op <= op_dec;
                   end
        OPB_START: if (rx_valid && is_digit) b <= OP_W'(dig);
        OPB:       if (rx_valid && is_digit) b <= acc[OP_W-1:0];
        CALC: begin
          rem     <= '0;
          div_cnt <= '0;
          case (op)
            OP_ADD:  res <= 32'(a) + 32'(b);
            OP_SUB:  res <= 32'(a) - 32'(b);
            OP_MUL:  res <= 32'(a) * 32'(b);
            default: res <= res;
          endcase
        end
        DIV: begin
          a       <= quo_d;
          rem     <= rem_d;
          div_cnt <= div_cnt + CNT_W'(1);
          if (div_cnt == CNT_W'(DIV_CYC - 1)) res <= 32'(quo_d);
        end
        SEND:      if (!tx_busy) begin
                     tx_data  <= res;
                     tx_valid <= 1'b1;
                   end
        ERR:       res <= '1;
        default:   ;
      endcase
      if (state_d == IDLE && state != IDLE) begin
        a  <= '0;
        b  <= '0;
        op <= OP_NONE;
      end
    end
  end

endmodule

// File: tb/tb_uart_cal_ctrl.sv
// tb_uart_cal_ctrl -- directed and randomized expression streams against an
// expression-level reference model, compared on every clock.
module tb_uart_cal_ctrl;
  localparam int unsigned DIV_CYC = 16;
  localparam longint      MAXV    = 65535;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_busy;
  logic        busy;
  logic        err;

  uart_cal_ctrl #(.OP_W(16), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  // Reference model: expression parse progress and the pending result
  int          phase;
  longint      ma, mb;
  byte         mop;
  bit          pend;
  logic [31:0] pend_val;
  int unsigned ready;
  longint      err_edge;
  logic [31:0] m_data;
  bit          exp_valid, exp_err, exp_busy;

  // Observations of the DUT
  int unsigned n_issue = 0, n_err = 0;
  logic [31:0] last_data = '0;
  int unsigned last_issue = 0, last_edge = 0;
  int unsigned i0, e0, t0;
  byte         q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic m_fault(input longint at, input int unsigned rdy);
    pend     = 1'b1;
    pend_val = 32'hFFFF_FFFF;
    err_edge = at;
    ready    = rdy;
    phase    = 0;
  endtask

  task automatic m_result(input longint v, input int unsigned lat);
    pend     = 1'b1;
    pend_val = 32'(v);
    ready    = cyc + lat;
    phase    = 0;
  endtask

  task automatic m_byte(input byte c);
    bit     dg;
    bit     opc;
    longint d;
    dg  = (c >= 8'h30) && (c <= 8'h39);
    opc = (c == "+") || (c == "-") || (c == "*") || (c == "/");
    d   = longint'(c) - 48;
    if (c == 8'h20) return;
    if (c == "C" || c == 8'h0D) begin
      phase = 0;
      return;
    end
    case (phase)
      0: if (dg) begin ma = d; phase = 1; end
         else m_fault(cyc, cyc + 2);
      1: if (dg && ma * 10 + d <= MAXV) ma = ma * 10 + d;
         else if (opc) begin mop = c; phase = 2; end
         else m_fault(cyc, cyc + 2);
      2: if (dg) begin mb = d; phase = 3; end
         else m_fault(cyc, cyc + 2);
      default:
         if (dg && mb * 10 + d <= MAXV) mb = mb * 10 + d;
         else if (c == "=") begin
           case (mop)
             "+":     m_result(ma + mb, 2);
             "-":     m_result(ma - mb, 2);
             "*":     m_result(ma * mb, 2);
             default: if (mb == 0) m_fault(cyc + 1, cyc + 3);
                      else         m_result(ma / mb, 2 + DIV_CYC);
           endcase
         end
         else m_fault(cyc, cyc + 2);
    endcase
  endtask

  // One clock: drive inputs, advance the model for this edge, compare after the edge
  task automatic step(input bit r, input bit rv, input byte rd, input bit tb);
    rst = r; rx_valid = rv; rx_data = rd; tx_busy = tb;
    @(posedge clk);
    cyc++;
    exp_valid = 1'b0;
    if (r) begin
      phase = 0; pend = 1'b0; m_data = '0; err_edge = -1;
    end else if (pend) begin
      if (cyc >= ready && !tb) begin
        exp_valid = 1'b1;
        m_data    = pend_val;
        pend      = 1'b0;
      end
    end else if (rv) begin
      m_byte(rd);
    end
    exp_err  = !r && (err_edge == longint'(cyc));
    exp_busy = pend && (err_edge != longint'(cyc));
    #1;
    check("cycle", {29'd0, tx_valid, err, busy, tx_data},
          {29'd0, exp_valid, exp_err, exp_busy, m_data});
    if (tx_valid) begin n_issue++; last_data = tx_data; last_issue = cyc; end
    if (err) n_err++;
  endtask

  task automatic send(input string s, input bit tb);
    for (int i = 0; i < s.len(); i++) step(1'b0, 1'b1, s[i], tb);
    last_edge = cyc;
  endtask

  task automatic idle(input int n, input bit tb);
    repeat (n) step(1'b0, 1'b0, 8'h00, tb);
  endtask

  function automatic bit rb();
    return $urandom_range(0, 3) == 0;
  endfunction

  function automatic longint pick();
    case ($urandom_range(0, 3))
      0:       return longint'($urandom_range(0, 9));
      1:       return longint'($urandom_range(0, 999));
      2:       return longint'($urandom_range(60000, 65535));
      default: return longint'($urandom_range(0, 70000));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    longint      ra, rbv;
    byte         ro;
    string       s;
    int unsigned pos;
    phase = 0; pend = 1'b0; m_data = '0; err_edge = -1; ma = 0; mb = 0; mop = "+";
    ready = 0; pend_val = '0;

    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("reset_out", {tx_valid, err, busy, tx_data}, 64'd0);

    i0 = n_issue; e0 = n_err;
    send("12+34=", 1'b0); idle(4, 1'b0);
    check("add_data", last_data, 32'h0000_002E);
    check("add_lat", last_issue - last_edge, 2);
    check("add_count", n_issue - i0, 1);
    check("add_noerr", n_err - e0, 0);

    send("100-250=", 1'b0); idle(4, 1'b0);
    check("sub_data", last_data, 32'hFFFF_FF6A);
    send("65535*65535=", 1'b0); idle(4, 1'b0);
    check("mul_data", last_data, 32'hFFFE_0001);
    send("100/7=", 1'b0); idle(DIV_CYC + 4, 1'b0);
    check("div_data", last_data, 32'h0000_000E);
    check("div_lat", last_issue - last_edge, 2 + DIV_CYC);

    e0 = n_err;
    send("7/0=", 1'b0); idle(6, 1'b0);
    check("div0_data", last_data, 32'hFFFF_FFFF);
    check("div0_err", n_err - e0, 1);
    check("div0_lat", last_issue - last_edge, 3);
    e0 = n_err;
    send("65536", 1'b0); idle(4, 1'b0);
    check("ovf_data", last_data, 32'hFFFF_FFFF);
    check("ovf_err", n_err - e0, 1);
    check("ovf_lat", last_issue - last_edge, 2);
    e0 = n_err; i0 = n_issue;
    send("1+=", 1'b0); idle(4, 1'b0);
    check("noB_err", n_err - e0, 1);
    check("noB_issue", n_issue - i0, 1);

    i0 = n_issue;
    send("2*3=", 1'b1); idle(20, 1'b1);
    send("9+9=", 1'b1); idle(30, 1'b1);
    t0 = cyc;
    idle(10, 1'b0);
    check("busy_count", n_issue - i0, 1);
    check("busy_data", last_data, 32'h0000_0006);
    check("busy_edge", last_issue, t0 + 1);

    send("12+3", 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    send("4+5=", 1'b0); idle(4, 1'b0);
    check("rst_data", last_data, 32'h0000_0009);
    i0 = n_issue;
    send("5+C2+2=", 1'b0); idle(4, 1'b0);
    check("clr_data", last_data, 32'h0000_0004);
    check("clr_count", n_issue - i0, 1);

    i0 = n_issue;
    send("5+", 1'b0); idle(100, 1'b0);
    check("wait_noissue", n_issue - i0, 0);
    send("3=", 1'b0); idle(4, 1'b0);
    check("wait_data", last_data, 32'h0000_0008);

    for (int t = 0; t < 80; t++) begin
      ra = pick(); rbv = pick();
      case ($urandom_range(0, 3))
        0:       ro = "+";
        1:       ro = "-";
        2:       ro = "*";
        default: ro = "/";
      endcase
      if (ro == "/" && $urandom_range(0, 4) == 0) rbv = 0;
      s = $sformatf("%0d%c%0d=", ra, ro, rbv);
      q.delete();
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      pos = $urandom_range(0, q.size() - 1);
      case ($urandom_range(0, 11))
        0:       q[pos] = "x";
        1:       q.insert(pos, 8'h20);
        2:       q.insert(pos, "C");
        3:       q.insert(pos, 8'h0D);
        4:       q.delete(pos);
        default: ;
      endcase
      foreach (q[i]) begin
        repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 8'h00, rb());
        step(1'b0, 1'b1, q[i], rb());
      end
      repeat ($urandom_range(0, 24)) step(1'b0, 1'b0, 8'h00, rb());
      if ($urandom_range(0, 19) == 0) step(1'b1, 1'b0, 8'h00, 1'b0);
    end
    idle(40, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
